// File: rtl/dt_mod_pkg.sv
// Shared definitions for the BPSK data modulator: symbol codes, gain FSM
// states, gain type and the symbol-to-target decode helper.
package dt_mod_pkg;

  // Symbol codes carried on dt32khz.
  localparam logic [1:0] SYM_POS  = 2'b11;
  localparam logic [1:0] SYM_NEG  = 2'b01;
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_BAD  = 2'b10;

  // Full-scale gain magnitude, Q1.15.
  localparam int AMP_DEFAULT = 32767;

  // Gain is signed 17-bit so that -AMP..+AMP and the ramp arithmetic fit.
  localparam int GW        = 17;
  localparam int FRAC_BITS = 15;

  typedef logic signed [GW-1:0] gain_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_STEADY = 2'd2
  } gain_state_e;

  // Map a symbol code to its gain target; the illegal code keeps the
  // current target so it can never start a ramp.
  function automatic gain_t decode_target(input logic [1:0] code,
                                          input gain_t      amp,
                                          input gain_t      cur);
    gain_t t;
    case (code)
      SYM_POS:  t = amp;
      SYM_NEG:  t = -amp;
      SYM_ZERO: t = '0;
      default:  t = cur;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/dt_bpsk_mod_if.sv
// Sample-stream bundle between the noise-enable stage and the modulator.
// master drives the carrier/symbol/enable, slave produces the modulated pair.
interface dt_bpsk_mod_if #(
  parameter int DW = 16
);

  logic                 noise_en;
  logic [1:0]           dt32khz;
  logic [2*DW-1:0]      sin_out;
  logic signed [DW-1:0] mod_i;
  logic signed [DW-1:0] mod_q;
  logic                 mod_valid;
  logic                 sym_err;

  modport master (
    output noise_en, dt32khz, sin_out,
    input  mod_i, mod_q, mod_valid, sym_err
  );

  modport slave (
    input  noise_en, dt32khz, sin_out,
    output mod_i, mod_q, mod_valid, sym_err
  );

endinterface

// File: rtl/dt_gain_ramp.sv
// Symbol decode and gain FSM. Symbol changes move the gain toward the new
// target in 2^RAMP_LOG2 equal steps, landing exactly on the target at the
// last step. Everything advances only on noise_en samples.
module dt_gain_ramp
  import dt_mod_pkg::*;
#(
  parameter int RAMP_LOG2 = 6,
  parameter int AMP       = AMP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_sys,
  input  logic       noise_en,
  input  logic [1:0] dt32khz,
  output gain_t      g,
  output logic       s1_en,
  output logic       sym_err
);

  localparam gain_t                AMP_G    = gain_t'(AMP);
  localparam logic [RAMP_LOG2-1:0] CNT_LAST = '1;

  // One bit wider than the gain so target - g never overflows.
  typedef logic signed [GW:0] diff_t;

  gain_state_e          state, state_n;
  gain_t                g_n;
  gain_t                target, target_n;
  gain_t                dec_target;
  diff_t                step, step_n;
  diff_t                ramp_diff, ramp_step, g_sum;
  logic [RAMP_LOG2-1:0] cnt, cnt_n;
  logic                 retarget;

  // Decode the symbol and precompute the step toward it from the present gain.
  always_comb begin
    dec_target = decode_target(dt32khz, AMP_G, target);
    retarget   = (dec_target != target);
    ramp_diff  = diff_t'(dec_target) - diff_t'(g);
    ramp_step  = ramp_diff >>> RAMP_LOG2;
    g_sum      = diff_t'(g) + step;
  end

  // Gain FSM next-state: idle start, ramp stepping/retarget, steady watch.
  // NOTE: every variable gets its hold value first, so a branch that does not
  // assign it keeps the register contents rather than inferring a latch.
  always_comb begin
    state_n  = state;
    g_n      = g;
    cnt_n    = cnt;
    step_n   = step;
    target_n = target;
    if (noise_en) begin
      case (state)
        ST_IDLE: begin
          target_n = dec_target;
          step_n   = ramp_step;
          cnt_n    = '0;
          g_n      = '0;
          state_n  = ST_RAMP;
        end
        ST_RAMP: begin
          if (retarget) begin
            // Restart from wherever the gain is now; g holds this sample.
            target_n = dec_target;
            step_n   = ramp_step;
            cnt_n    = '0;
          end else if (cnt == CNT_LAST) begin
            // Snap to the target to absorb the truncation of step.
            g_n     = target;
            state_n = ST_STEADY;
          end else begin
            g_n   = g_sum[GW-1:0];
            cnt_n = cnt + RAMP_LOG2'(1);
          end
        end
        ST_STEADY: begin
          if (retarget) begin
            target_n = dec_target;
            step_n   = ramp_step;
            cnt_n    = '0;
            state_n  = ST_RAMP;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Gain FSM state registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state  <= ST_IDLE;
      g      <= '0;
      cnt    <= '0;
      step   <= '0;
      target <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      cnt    <= cnt_n;
      step   <= step_n;
      target <= target_n;
    end
  end

  // Illegal-code flag, one cycle after the offending enabled sample.
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      sym_err <= 1'b0;
    end else begin
      sym_err <= noise_en && (dt32khz == SYM_BAD);
    end
  end

  // Stage-1 capture happens on the same edge as the gain update, so the
  // captured g is the value before that update.
  assign s1_en = noise_en;

endmodule

// File: rtl/dt_bpsk_mod.sv
// BPSK data modulator: splits the quadrature carrier, scales both channels
// by the ramped symbol gain in a 2-stage pipeline and saturates the result.
module dt_bpsk_mod
  import dt_mod_pkg::*;
#(
  parameter int DW        = 16,
  parameter int RAMP_LOG2 = 6,
  parameter int AMP       = AMP_DEFAULT
) (
  input logic            clk,
  input logic            rst_sys,
  dt_bpsk_mod_if.slave   bus
);

  localparam int PW = DW + GW;

  typedef logic signed [DW-1:0] samp_t;
  typedef logic signed [PW-1:0] prod_t;

  localparam prod_t SAT_HI = prod_t'((2 ** (DW - 1)) - 1);
  localparam prod_t SAT_LO = -SAT_HI;

  // carrier * gain, rescaled from Q1.15 with a flooring shift, clamped to
  // the symmetric range so -full-scale is never produced.
  function automatic samp_t scale_sat(input samp_t c, input gain_t gg);
    prod_t p;
    prod_t s;
    samp_t r;
    p = prod_t'(c) * prod_t'(gg);
    s = p >>> FRAC_BITS;
    if (s > SAT_HI) begin
      r = SAT_HI[DW-1:0];
    end else if (s < SAT_LO) begin
      r = SAT_LO[DW-1:0];
    end else begin
      r = s[DW-1:0];
    end
    return r;
  endfunction

  gain_t g;
  logic  s1_en;
  logic  sym_err;

  samp_t s1_i, s1_q;
  gain_t s1_g;
  logic  s1_vld;

  samp_t sat_i, sat_q;
  samp_t mod_i, mod_q;
  logic  mod_valid;

  dt_gain_ramp #(
    .RAMP_LOG2 (RAMP_LOG2),
    .AMP       (AMP)
  ) u_gain (
    .clk      (clk),
    .rst_sys  (rst_sys),
    .noise_en (bus.noise_en),
    .dt32khz  (bus.dt32khz),
    .g        (g),
    .s1_en    (s1_en),
    .sym_err  (sym_err)
  );

  // Stage 1: capture I, Q and the gain in effect for this sample.
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      s1_i   <= '0;
      s1_q   <= '0;
      s1_g   <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= s1_en;
      if (s1_en) begin
        s1_i <= bus.sin_out[2*DW-1:DW];
        s1_q <= bus.sin_out[DW-1:0];
        s1_g <= g;
      end
    end
  end

  // Stage 2 datapath: multiply, shift and saturate both channels.
  always_comb begin
    sat_i = scale_sat(s1_i, s1_g);
    sat_q = scale_sat(s1_q, s1_g);
  end

  // Stage 2: register the scaled pair; outputs hold between valid samples.
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      mod_i     <= '0;
      mod_q     <= '0;
      mod_valid <= 1'b0;
    end else begin
      mod_valid <= s1_vld;
      if (s1_vld) begin
        mod_i <= sat_i;
        mod_q <= sat_q;
      end
    end
  end

  assign bus.mod_i     = mod_i;
  assign bus.mod_q     = mod_q;
  assign bus.mod_valid = mod_valid;
  assign bus.sym_err   = sym_err;

endmodule

// File: tb/tb_dt_bpsk_mod.sv
// Scoreboard bench for dt_bpsk_mod: stimulus pushes the expected I/Q pair
// for every enabled sample, a monitor pops and compares on mod_valid and
// tracks the 2-cycle valid delay and the 1-cycle sym_err delay.
module tb_dt_bpsk_mod;
  import dt_mod_pkg::*;

  logic clk     = 1'b0;
  logic rst_sys = 1'b0;

  always #5 clk = ~clk;

  dt_bpsk_mod_if #(.DW(16)) dut_if ();

  dt_bpsk_mod #(
    .DW        (16),
    .RAMP_LOG2 (6),
    .AMP       (32767)
  ) dut (
    .clk     (clk),
    .rst_sys (rst_sys),
    .bus     (dut_if.slave)
  );

  typedef struct {
    int i;
    int q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_i   = 0;
  int   last_q   = 0;
  logic h0 = 1'b0, h1 = 1'b0, e0 = 1'b0;
  bit   rel_next = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Expected datapath value: (carrier * g) >>> 15, clamped to +/-32767.
  function automatic int exp_mul(input int c, input int g);
    longint p;
    longint s;
    p = longint'(c) * longint'(g);
    s = p >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32767) s = -32767;
    return int'(s);
  endfunction

  // Enable and illegal-code history: mod_valid lags noise_en by two edges,
  // sym_err lags the offending sample by one.
  always @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      h0 <= 1'b0;
      h1 <= 1'b0;
      e0 <= 1'b0;
    end else begin
      h0 <= dut_if.noise_en;
      h1 <= h0;
      e0 <= dut_if.noise_en && (dut_if.dt32khz == 2'b10);
    end
  end

  // Monitor: compare just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    check("mod_valid", int'(dut_if.mod_valid), int'(h1));
    check("sym_err", int'(dut_if.sym_err), int'(e0));
    if (dut_if.mod_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: unexpected output i=%0d q=%0d, expected no sample at %0t",
                 dut_if.mod_i, dut_if.mod_q, $time);
      end else begin
        e = sb.pop_front();
        check("mod_i", int'(dut_if.mod_i), e.i);
        check("mod_q", int'(dut_if.mod_q), e.q);
        last_i = e.i;
        last_q = e.q;
      end
    end else begin
      check("mod_i_hold", int'(dut_if.mod_i), last_i);
      check("mod_q_hold", int'(dut_if.mod_q), last_q);
    end
  end

  task automatic drive_exp(input bit en, input logic [1:0] code,
                           input logic signed [15:0] iv, input logic signed [15:0] qv,
                           input int ei, input int eq);
    exp_t e;
    @(negedge clk);
    if (rel_next) begin
      rst_sys  = 1'b0;
      rel_next = 1'b0;
    end
    dut_if.noise_en = en;
    dut_if.dt32khz  = code;
    dut_if.sin_out  = {iv, qv};
    if (en) begin
      e.i = ei;
      e.q = eq;
      sb.push_back(e);
    end
  endtask

  // One enabled sample that must be scaled by gain g_seen.
  task automatic drive(input logic [1:0] code, input logic signed [15:0] iv,
                       input logic signed [15:0] qv, input int g_seen);
    drive_exp(1'b1, code, iv, qv, exp_mul(int'(iv), g_seen), exp_mul(int'(qv), g_seen));
  endtask

  // Disabled cycle with junk on the data lines (including the illegal code).
  task automatic gap();
    drive_exp(1'b0, 2'b10, 16'sh7abc, 16'sh1234, 0, 0);
  endtask

  // Entry sample sees g0 unchanged, then n ramp samples see g0 + j*step.
  // gap_every != 0 inserts two disabled cycles after every gap_every-th sample.
  task automatic ramp_seg(input logic [1:0] code, input logic signed [15:0] iv,
                          input logic signed [15:0] qv, input int g0, input int step,
                          input int n, input int gap_every);
    drive(code, iv, qv, g0);
    for (int j = 0; j < n; j++) begin
      drive(code, iv, qv, g0 + j * step);
      if (gap_every != 0 && (j % gap_every) == 0) begin
        gap();
        gap();
      end
    end
  endtask

  task automatic steady(input logic [1:0] code, input logic signed [15:0] iv,
                        input logic signed [15:0] qv, input int g, input int n);
    for (int k = 0; k < n; k++) drive(code, iv, qv, g);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dut_if.noise_en = 1'b0;
    dut_if.dt32khz  = 2'b00;
    dut_if.sin_out  = '0;
    #2 rst_sys = 1'b1;
    #1;
    check("rst_mod_i", int'(dut_if.mod_i), 0);
    check("rst_mod_q", int'(dut_if.mod_q), 0);
    check("rst_mod_valid", int'(dut_if.mod_valid), 0);
    check("rst_sym_err", int'(dut_if.sym_err), 0);
    repeat (3) @(posedge clk);

    // 1: release with noise_en high, ramp 0 -> +32767 in steps of 511.
    rel_next = 1'b1;
    ramp_seg(2'b11, 16'sh4000, 16'sh4000, 0, 511, 64, 0);
    for (int k = 0; k < 3; k++) drive_exp(1'b1, 2'b11, 16'sh4000, 16'sh4000, 16383, 16383);

    // 2: +AMP -> -AMP, step -1024; Q at negative full scale.
    ramp_seg(2'b01, 16'sh4000, 16'sh8000, 32767, -1024, 64, 0);
    for (int k = 0; k < 3; k++) drive_exp(1'b1, 2'b01, 16'sh4000, 16'sh8000, -16384, 32767);

    // 3: illegal code in STEADY leaves gain and outputs unchanged.
    drive_exp(1'b1, 2'b10, 16'sh4000, 16'sh8000, -16384, 32767);
    for (int k = 0; k < 2; k++) drive_exp(1'b1, 2'b01, 16'sh4000, 16'sh8000, -16384, 32767);

    // 4: back to +AMP, then 11->01, retarget to 11 at g = 12287 (step 320).
    ramp_seg(2'b11, 16'sh4000, 16'sh2000, -32767, 1023, 64, 0);
    steady(2'b11, 16'sh4000, 16'sh2000, 32767, 2);
    ramp_seg(2'b01, 16'sh4000, 16'sh2000, 32767, -1024, 20, 0);
    ramp_seg(2'b11, 16'sh4000, 16'sh2000, 12287, 320, 64, 0);
    for (int k = 0; k < 2; k++) drive_exp(1'b1, 2'b11, 16'sh4000, 16'sh2000, 16383, 8191);

    // 5: ramp to -AMP with noise_en gaps (1-0-0-1 pattern).
    ramp_seg(2'b01, 16'sh4000, 16'sh7fff, 32767, -1024, 64, 3);
    steady(2'b01, 16'sh4000, 16'sh7fff, -32767, 2);
    gap();
    gap();

    // 6: asynchronous reset mid-ramp, released with noise_en high.
    ramp_seg(2'b11, 16'sh4000, 16'sh4000, -32767, 1023, 10, 0);
    @(posedge clk);
    #3 rst_sys = 1'b1;
    sb.delete();
    last_i = 0;
    last_q = 0;
    #1;
    check("midrst_mod_i", int'(dut_if.mod_i), 0);
    check("midrst_mod_q", int'(dut_if.mod_q), 0);
    check("midrst_mod_valid", int'(dut_if.mod_valid), 0);
    check("midrst_sym_err", int'(dut_if.sym_err), 0);
    rel_next = 1'b1;
    @(posedge clk);
    ramp_seg(2'b11, 16'sh4000, 16'shc000, 0, 511, 64, 0);
    for (int k = 0; k < 2; k++) drive_exp(1'b1, 2'b11, 16'sh4000, 16'shc000, 16383, -16384);

    // Drain the pipeline with a bounded wait.
    gap();
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dt_bpsk_mod.md
# dt_bpsk_mod

- Downstream of the reset/noise-enable stage.
- Consumes the stabilized 32-bit quadrature carrier `sin_out`, the 2-bit data symbol `dt32khz` and the sample enable `noise_en`.
- Produces a 16-bit I/Q pair modulated by the data symbol.
- Symbol changes are amplitude-ramped over a fixed number of enabled samples rather than stepped, to limit spectral splatter.

## Interface

Parameters:
- `DW`, 16: carrier and output sample width, signed.
- `RAMP_LOG2`, 6: ramp length is 2^RAMP_LOG2 enabled samples.
- `AMP`, 32767: full-scale gain magnitude, Q1.15.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_sys` in 1: reset, asynchronous, active-high.
- `noise_en` in 1: sample enable; `sin_out` and `dt32khz` are valid while high.
- `dt32khz` in 2: symbol code (11 = +1, 01 = −1, 00 = zero, 10 = illegal).
- `sin_out` in 32: carrier; [31:16] = I, [15:0] = Q, each signed DW.
- `mod_i` out DW: modulated I sample.
- `mod_q` out DW: modulated Q sample.
- `mod_valid` out 1: output strobe, one per enabled input sample.
- `sym_err` out 1: single-cycle pulse on an illegal code.

## Operation

Symbol decode:
- Performed only on cycles with `noise_en`=1.
- Decoded target: 11 → +AMP, 01 → −AMP, 00 → 0.
- Code 10: target unchanged; `sym_err`=1 for that cycle.

Gain FSM (states IDLE, RAMP, STEADY), signed 17-bit gain `g`. Every transition and gain update happens only when `noise_en`=1; otherwise state, `g` and the ramp counter hold.
- IDLE: `g`=0. On the first enabled cycle, latch the target, go to RAMP with start gain 0.
- RAMP: on entry:
  - `diff` = target − `g`, signed 18-bit.
  - `step` = `diff` >>> RAMP_LOG2 (arithmetic, floor).
  - counter `cnt` = 0.
- RAMP, each enabled cycle:
  - If `cnt` < 2^RAMP_LOG2 − 1: `g` += `step`, `cnt`++.
  - If `cnt` = 2^RAMP_LOG2 − 1: `g` = target exactly, go to STEADY.
- STEADY: if the decoded target ≠ current target, latch the new target and re-enter RAMP from the current `g`.
- New symbol during RAMP: recompute `diff`/`step` from the current `g`, clear `cnt`, continue in RAMP. No glitch and no skipped sample.
- The same symbol repeated has no effect.

Datapath:
- Product per channel: carrier (DW signed) × `g` (17 signed) → 33-bit product.
- Output = product >>> 15, then saturated to ±32767. Arithmetic shift floors.

Reset, asynchronous, any time including mid-ramp:
- State IDLE, `g`=0, `cnt`=0, target 0.
- `mod_i`=`mod_q`=0, `mod_valid`=0, `sym_err`=0.

## Timing

- Pipeline is 2 stages:
  - Stage 1 registers I, Q and the current `g`.
  - Stage 2 registers the multiply/shift/saturate result.
- `mod_valid` is `noise_en` delayed by exactly 2 cycles. `mod_i`/`mod_q` change only when `mod_valid`=1 and hold otherwise.
- The `g` update and the stage-1 capture happen on the same edge. The output at cycle n+2 uses the `g` in effect before the update at cycle n.
- `sym_err` is registered, 1 cycle after the offending enabled sample.
- Back-to-back `noise_en` is supported at full clock rate; gaps in `noise_en` are allowed with no sample loss.
- Releasing `rst_sys` with `noise_en` already high: the first enabled edge after release is the IDLE→RAMP cycle.

## Structure

- Package `dt_mod_pkg`:
  - Symbol code constants `SYM_POS`=2'b11, `SYM_NEG`=2'b01, `SYM_ZERO`=2'b00.
  - Gain FSM state enum.
  - Default AMP.
- Sub-module `dt_gain_ramp`: decode, FSM, `g`/`cnt`/`step`, `sym_err`. Output `g` and a stage-1 enable.
- Top `dt_bpsk_mod`: carrier split, 2-stage multiply pipeline, saturation, `mod_valid` delay line.

## Test plan

1. Reset → all outputs 0. Then hold `noise_en`=1, `dt32khz`=11, I=Q=0x4000 → `g` reaches 32193 after 63 enabled samples and 32767 on the 64th. Steady `mod_i`=`mod_q`=16383.
2. STEADY +AMP, switch `dt32khz` to 01, I=0x4000 → `step`=−1024. `g` reaches −32767 on the 64th sample. Final `mod_i`=−16384.
3. Code 10 injected in STEADY → `sym_err` single-cycle pulse one cycle later. `g` and outputs unchanged.
4. Switch 11→01, then back to 11 after 20 samples → ramp restarts from `g`=32767−20×1024=12287. `step`=(32767−12287)>>>6=320. Ends at 32767.
5. Toggle `noise_en` 1-0-0-1 pattern during a ramp → `mod_valid` mirrors it 2 cycles later. `g` advances only on enabled samples; the ramp takes exactly 64 enabled samples.
6. Assert `rst_sys` mid-ramp for 1 cycle (asynchronous, between clock edges) → outputs 0 immediately. After release, ramp restarts from 0 in IDLE→RAMP.
